// File: rtl/serial_addsub_unit_pkg.sv
// Shared types and helpers for the digit-serial add/subtract unit.
//   state_e   : controller states (IDLE, CALC, HOLD)
//   MODE_*    : encoding of the M input
//   cnt_width : width of the digit counter for a given WIDTH/DIGIT pair
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Digit counter width, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width,
                                            input int unsigned digit);
    int unsigned w;
    w = $clog2(width / digit);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_addsub_unit_addsub_digit.sv
// DIGIT-bit ripple-carry adder slice used once per clock by the serial unit.
//   a, b      : digit operands (b already inverted for subtraction)
//   cin       : carry into bit 0
//   s         : digit sum
//   cout      : carry out of the top bit
//   c_msb_in  : carry into the top bit (overflow detection on the last digit)
module addsub_digit #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  always_comb begin
    logic [DIGIT:0] c;
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout     = c[DIGIT];
    c_msb_in = c[DIGIT-1];
  end

endmodule

// File: rtl/serial_addsub_unit.sv
// Digit-serial WIDTH-bit two's-complement adder/subtractor, DIGIT bits/clock.
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (A, B, M sampled on accept)
//   A, B, M             : operands, M=0 add, M=1 subtract
//   out_valid/out_ready : result handshake, result held until accepted
//   S, Cout, V, Z, N    : result, carry out (1 = no borrow when subtracting),
//                         signed overflow, zero, negative
module serial_addsub_unit
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             Z,
  output logic             N
);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_addsub_unit: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              cout_q, cout_d;
  logic              v_q, v_d;
  logic              z_q, z_d;
  logic              n_q, n_d;

  logic [DIGIT-1:0]  dig_s;
  logic              dig_cout;
  logic              dig_c_msb_in;
  logic [WIDTH-1:0]  acc_shift;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a        (a_q[DIGIT-1:0]),
    .b        (b_q[DIGIT-1:0]),
    .cin      (carry_q),
    .s        (dig_s),
    .cout     (dig_cout),
    .c_msb_in (dig_c_msb_in)
  );

  // New digit enters at the MSB end; after NDIG shifts the LSB digit has
  // reached bit 0. Written with shifts so DIGIT == WIDTH needs no special case.
  assign acc_shift = (acc_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    v_d     = v_q;
    z_d     = z_q;
    n_d     = n_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = (M == MODE_SUB) ? ~B : B;
          carry_d = (M == MODE_SUB);
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_shift;
        carry_d = dig_cout;
        cnt_d   = (cnt_q == LAST_DIG) ? '0 : cnt_q + 1'b1;
        if (cnt_q == LAST_DIG) begin
          state_d = HOLD;
          s_d     = acc_shift;
          cout_d  = dig_cout;
          v_d     = dig_cout ^ dig_c_msb_in;
          z_d     = (acc_shift == '0);
          n_d     = acc_shift[WIDTH-1];
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign S         = s_q;
  assign Cout      = cout_q;
  assign V         = v_q;
  assign Z         = z_q;
  assign N         = n_q;

endmodule

// File: doc/serial_addsub_unit.md
Name: serial_addsub_unit

Overview:
Parametrised, digit-serial universal adder/subtractor, the multi-cycle successor to the 4-bit combinational add/sub unit.
- Mode input M selects A+B (M=0) or A-B (M=1) on WIDTH-bit two's-complement operands.
- The datapath processes DIGIT bits per clock, trading latency for area.
- Valid/ready handshakes on input and output let it sit between lab stimulus FSMs and display/result registers.

Parameters:
WIDTH, 8, operand/result width in bits; must be >= 2.
DIGIT, 2, bits processed per clock; WIDTH % DIGIT must be 0 (elaboration error otherwise).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands and mode valid
in_ready  output  1  unit can accept operands
A  input  WIDTH  operand A
B  input  WIDTH  operand B
M  input  1  0 = add, 1 = subtract
out_valid  output  1  result valid, held until accepted
out_ready  input  1  consumer accepts result
S  output  WIDTH  sum/difference
Cout  output  1  carry out of MSB (in subtract mode, 1 = no borrow)
V  output  1  signed overflow
Z  output  1  S == 0
N  output  1  S[WIDTH-1]

Behaviour:
- Reset: synchronous, active-high, on clk rising edge.
  - State returns to IDLE; any in-flight operation is discarded.
  - in_ready=1 (from the first cycle after reset deasserts), out_valid=0, S=0, Cout=0, V=0, Z=0, N=0.
  - rst has priority over all handshakes.
- FSM states IDLE, CALC, HOLD:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch A, B^{WIDTH{M}}, carry=M, digit count=0, mode; go to CALC.
  - CALC: in_ready=0, out_valid=0. Each cycle adds the low DIGIT bits of the A/B shift registers plus carry, shifts the result digit into the S shift register from the MSB side, and increments the count. After NDIG=WIDTH/DIGIT cycles, go to HOLD.
  - HOLD: out_valid=1 and S/Cout/V/Z/N are stable. On out_ready, go to IDLE (in_ready=1 next cycle). Without out_ready, stay in HOLD indefinitely.
- Latency: accept edge t → out_valid high after edge t+NDIG. Back-to-back throughput is one result per NDIG+2 cycles with out_ready tied high.
- Arithmetic:
  - S = (A + (B^M·1s) + M) mod 2^WIDTH.
  - Cout = carry out of bit WIDTH-1.
  - V = carry into MSB XOR carry out of MSB, taken from the last digit.
- Flags: Z and N are computed from the final S. All result outputs are registered and update only on the CALC→HOLD transition. Between operations they hold the last result.
- Boundaries:
  - in_valid is ignored outside IDLE; operand changes during CALC have no effect.
  - DIGIT=WIDTH gives a single CALC cycle.
  - out_ready asserted in CALC is ignored; only HOLD consumes it.
  - The digit counter wraps cleanly; no state other than IDLE/CALC/HOLD is reachable. An illegal encoding recovers to IDLE.

Decomposition:
- Package serial_addsub_pkg:
  - state enum (IDLE, CALC, HOLD);
  - mode constants MODE_ADD=1'b0, MODE_SUB=1'b1;
  - function for the counter width, $clog2(WIDTH/DIGIT) with minimum 1.
- One sub-module, addsub_digit: a DIGIT-bit ripple adder with inputs a, b, cin and outputs s, cout, and c_msb_in (carry into its top bit, used for V).

Test Plan:
- WIDTH=8, DIGIT=2. Reset 3 cycles, then ADD 0x05+0x03 → out_valid exactly 4 cycles after accept; S=0x08, Cout=0, V=0, Z=0, N=0.
- ADD 0x7F+0x01 → S=0x80, V=1, N=1, Cout=0. Then ADD 0xFF+0x01 → S=0x00, Cout=1, Z=1, V=0.
- SUB 0x09-0x04 → S=0x05, Cout=1. SUB 0x03-0x08 → S=0xFB, Cout=0, N=1. SUB 0x80-0x01 → S=0x7F, V=1, Cout=1.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD → S/flags stable, in_ready=0; toggling A/B/in_valid has no effect. out_ready=1 → IDLE and in_ready=1 next cycle.
- Assert rst during CALC (2nd digit cycle) → next cycle IDLE, all outputs 0, in_ready=1. A new ADD 0x10+0x20 then gives S=0x30.
- Re-run with DIGIT=8 (1-cycle CALC) and DIGIT=1 (8 cycles) → latency equals NDIG. Random A/B/M against a reference model for 1000 operations.
